// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output reorder block.
//   FFT_N_LOG2 / FFT_N : default frame geometry (1024 points)
//   DATA_W             : default sample component width
//   bank_state_t       : ping-pong bank life cycle
//   bitrev()           : reverse the low 'width' bits of 'value'
package fft_pkg;

   localparam int FFT_N_LOG2 = 10;
   localparam int FFT_N      = 1 << FFT_N_LOG2;
   localparam int DATA_W     = 32;

   typedef enum logic [1:0] {
      EMPTY    = 2'd0,
      FILLING  = 2'd1,
      FULL     = 2'd2,
      DRAINING = 2'd3
   } bank_state_t;

   // Shifting form keeps every index constant, so it elaborates cleanly for
   // any width up to 32.
   function automatic logic [31:0] bitrev(input int width, input logic [31:0] value);
      logic [31:0] r;
      logic [31:0] v;
      r = '0;
      v = value;
      for (int i = 0; i < 32; i++) begin
         if (i < width) begin
            r = {r[30:0], v[0]};
            v = v >> 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/dual_port_ram.sv
// Simple dual-port RAM: two write ports, registered read on port A.
//   i_clk            : clock
//   we_a/addr_a      : port A write enable / address (also the read address)
//   wdata_a/rdata_a  : port A write data / registered read data
//   we_b/addr_b      : port B write enable / address
//   wdata_b          : port B write data
// Contents are not reset.
module dual_port_ram #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 10
) (
   input  logic              i_clk,
   input  logic              we_a,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [DATA_W-1:0] wdata_a,
   output logic [DATA_W-1:0] rdata_a,
   input  logic              we_b,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic [DATA_W-1:0] wdata_b
);

   logic [DATA_W-1:0] mem [1 << ADDR_W];

   always_ff @(posedge i_clk) begin
      if (we_a) mem[addr_a] <= wdata_a;
      if (we_b) mem[addr_b] <= wdata_b;
      rdata_a <= mem[addr_a];
   end

endmodule

// File: rtl/fft_out_reorder.sv
// Converts bit-reversed FFT output pairs into a natural-order sample stream.
// Two ping-pong banks (real + imag RAM each) hold one frame apiece; a pair
// p lands in bins bitrev({p,0}) and bitrev({p,1}) in one cycle, and the
// reader streams k = 0..N-1 through a 2-entry skid buffer.
//
// Ports:
//   i_clk, i_reset          : clock, async active-low reset
//   i_valid_in              : input pair valid (no backpressure)
//   i_data_a_*/i_data_b_*   : samples A and B of the pair
//   i_ready                 : downstream takes the output sample
//   o_valid_out, o_data_*   : output sample and its valid
//   o_index, o_sof, o_eof   : bin index, first bin, last bin
//   o_overflow              : sticky, a pair was dropped
//
// Bank state | meaning
// EMPTY      | free, nothing written yet
// FILLING    | first pair written, frame incomplete
// FULL       | last pair written, waiting for the reader
// DRAINING   | first read issued, released when bin N-1 leaves downstream
module fft_out_reorder
   import fft_pkg::*;
#(
   parameter int DATA_W = fft_pkg::DATA_W,
   parameter int N_LOG2 = FFT_N_LOG2
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_valid_in,
   input  logic [DATA_W-1:0] i_data_a_real,
   input  logic [DATA_W-1:0] i_data_a_imag,
   input  logic [DATA_W-1:0] i_data_b_real,
   input  logic [DATA_W-1:0] i_data_b_imag,
   input  logic              i_ready,
   output logic              o_valid_out,
   output logic [DATA_W-1:0] o_data_real,
   output logic [DATA_W-1:0] o_data_imag,
   output logic [N_LOG2-1:0] o_index,
   output logic              o_sof,
   output logic              o_eof,
   output logic              o_overflow
);

   localparam int PAIR_W = N_LOG2 - 1;
   localparam logic [N_LOG2-1:0] IDX_LAST  = '1;
   localparam logic [PAIR_W-1:0] PAIR_LAST = '1;

   bank_state_t       bank_st     [2];
   bank_state_t       bank_st_nxt [2];

   logic              wr_sel;
   logic [PAIR_W-1:0] wr_pair;
   logic              rd_sel;
   logic              rd_active;
   logic [N_LOG2-1:0] rd_cnt;

   logic              inflight;
   logic              inflight_bank;
   logic [N_LOG2-1:0] inflight_idx;

   logic              out_bank;
   logic              sk_valid;
   logic              sk_bank;
   logic [DATA_W-1:0] sk_re;
   logic [DATA_W-1:0] sk_im;
   logic [N_LOG2-1:0] sk_idx;

   logic [DATA_W-1:0] ram_rd_re [2];
   logic [DATA_W-1:0] ram_rd_im [2];
   logic [DATA_W-1:0] ram_re;
   logic [DATA_W-1:0] ram_im;

   logic [N_LOG2-1:0] wr_addr_a;
   logic [N_LOG2-1:0] wr_addr_b;
   logic              pop;
   logic              last_pop;
   logic              wr_free;
   logic              wr_en;
   logic              wr_drop;
   logic              wr_last;
   logic [1:0]        fill_cnt;
   logic              rd_room;
   logic              rd_issue;
   logic              rd_start;
   logic              rd_last;

   assign wr_addr_a = N_LOG2'(bitrev(N_LOG2, 32'({wr_pair, 1'b0})));
   assign wr_addr_b = N_LOG2'(bitrev(N_LOG2, 32'({wr_pair, 1'b1})));

   assign pop      = o_valid_out && i_ready;
   assign last_pop = pop && (o_index == IDX_LAST);

   // A draining bank whose final sample leaves this cycle is already free.
   assign wr_free = (bank_st[wr_sel] == EMPTY) || (bank_st[wr_sel] == FILLING) ||
                    (last_pop && (out_bank == wr_sel));
   assign wr_en   = i_valid_in && wr_free;
   assign wr_drop = i_valid_in && !wr_free;
   assign wr_last = (wr_pair == PAIR_LAST);

   // Head + skid + in-flight read never exceeds two samples, so a stall can
   // always be absorbed without losing the read already issued.
   assign fill_cnt = 2'(o_valid_out) + 2'(sk_valid) + 2'(inflight);
   assign rd_room  = pop || (fill_cnt < 2'd2);
   assign rd_start = !rd_active && (bank_st[rd_sel] == FULL) && rd_room;
   assign rd_issue = (rd_active && rd_room) || rd_start;
   assign rd_last  = (rd_cnt == IDX_LAST);

   assign ram_re = ram_rd_re[inflight_bank];
   assign ram_im = ram_rd_im[inflight_bank];

   assign o_sof = o_valid_out && (o_index == '0);
   assign o_eof = o_valid_out && (o_index == IDX_LAST);

   always_comb begin
      for (int b = 0; b < 2; b++) begin
         bank_st_nxt[b] = bank_st[b];
         if (last_pop && (out_bank == 1'(b)))  bank_st_nxt[b] = EMPTY;
         if (rd_start && (rd_sel == 1'(b)))    bank_st_nxt[b] = DRAINING;
         if (wr_en && (wr_sel == 1'(b)))       bank_st_nxt[b] = wr_last ? FULL : FILLING;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         bank_st[0] <= EMPTY;
         bank_st[1] <= EMPTY;
      end else begin
         bank_st[0] <= bank_st_nxt[0];
         bank_st[1] <= bank_st_nxt[1];
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         wr_sel     <= 1'b0;
         wr_pair    <= '0;
         o_overflow <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_pair <= wr_pair + 1'b1;
            if (wr_last) wr_sel <= ~wr_sel;
         end
         if (wr_drop) o_overflow <= 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         rd_sel        <= 1'b0;
         rd_active     <= 1'b0;
         rd_cnt        <= '0;
         inflight      <= 1'b0;
         inflight_bank <= 1'b0;
         inflight_idx  <= '0;
      end else begin
         inflight      <= rd_issue;
         inflight_bank <= rd_sel;
         inflight_idx  <= rd_cnt;
         if (rd_issue) begin
            rd_active <= !rd_last;
            if (rd_last) begin
               rd_sel <= ~rd_sel;
               rd_cnt <= '0;
            end else begin
               rd_cnt <= rd_cnt + 1'b1;
            end
         end
      end
   end

   // Output register is the head of the skid FIFO; sk_* is the second slot.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         o_valid_out <= 1'b0;
         o_data_real <= '0;
         o_data_imag <= '0;
         o_index     <= '0;
         out_bank    <= 1'b0;
         sk_valid    <= 1'b0;
         sk_bank     <= 1'b0;
         sk_re       <= '0;
         sk_im       <= '0;
         sk_idx      <= '0;
      end else if (!o_valid_out || pop) begin
         if (sk_valid) begin
            o_valid_out <= 1'b1;
            o_data_real <= sk_re;
            o_data_imag <= sk_im;
            o_index     <= sk_idx;
            out_bank    <= sk_bank;
            sk_valid    <= inflight;
            if (inflight) begin
               sk_re   <= ram_re;
               sk_im   <= ram_im;
               sk_idx  <= inflight_idx;
               sk_bank <= inflight_bank;
            end
         end else begin
            o_valid_out <= inflight;
            if (inflight) begin
               o_data_real <= ram_re;
               o_data_imag <= ram_im;
               o_index     <= inflight_idx;
               out_bank    <= inflight_bank;
            end
         end
      end else if (inflight) begin
         sk_valid <= 1'b1;
         sk_re    <= ram_re;
         sk_im    <= ram_im;
         sk_idx   <= inflight_idx;
         sk_bank  <= inflight_bank;
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      logic              we;
      logic [N_LOG2-1:0] addr_a;

      // The bank being written is never the one being read, so port A is
      // shared between the A-sample write and the drain read.
      assign we     = wr_en && (wr_sel == 1'(b));
      assign addr_a = we ? wr_addr_a : rd_cnt;

      dual_port_ram #(.DATA_W(DATA_W), .ADDR_W(N_LOG2)) u_ram_re (
         .i_clk   (i_clk),
         .we_a    (we),
         .addr_a  (addr_a),
         .wdata_a (i_data_a_real),
         .rdata_a (ram_rd_re[b]),
         .we_b    (we),
         .addr_b  (wr_addr_b),
         .wdata_b (i_data_b_real)
      );

      dual_port_ram #(.DATA_W(DATA_W), .ADDR_W(N_LOG2)) u_ram_im (
         .i_clk   (i_clk),
         .we_a    (we),
         .addr_a  (addr_a),
         .wdata_a (i_data_a_imag),
         .rdata_a (ram_rd_im[b]),
         .we_b    (we),
         .addr_b  (wr_addr_b),
         .wdata_b (i_data_b_imag)
      );
   end

endmodule

// File: doc/fft_out_reorder.md
FFT_OUT_REORDER -- requirements
Module: fft_out_reorder

Interface
REQ-001 SHALL have parameter DATA_W, default 32, sample component width (two's complement).
REQ-002 SHALL have parameter N_LOG2, default 10, log2 of frame length (1024 points, 512 pairs per frame).
REQ-003 Ports:
- i_clk  in  1  single clock; all logic on rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_valid_in  in  1  input pair valid; no backpressure toward the upstream stage.
- i_data_a_real, i_data_a_imag  in  DATA_W  sample A of the pair.
- i_data_b_real, i_data_b_imag  in  DATA_W  sample B of the pair.
- i_ready  in  1  downstream accepts the output sample this cycle.
- o_valid_out  out  1  output sample valid.
- o_data_real, o_data_imag  out  DATA_W  natural-order output sample.
- o_index  out  N_LOG2  bin index k of the output sample.
- o_sof  out  1  high with k = 0.
- o_eof  out  1  high with k = N-1.
- o_overflow  out  1  sticky: an input pair was dropped.

Function
REQ-004 The p-th accepted pair of a frame (p = 0..511) SHALL be written as A -> bin bitrev(N_LOG2, {p,0}) and B -> bin bitrev(N_LOG2, {p,1}), both in the same cycle.
REQ-005 Storage SHALL be ping-pong: two banks, each N entries for real and imag; one bank fills while the other drains.
REQ-006 Each bank SHALL carry a state: EMPTY -> FILLING (first pair written) -> FULL (pair 511 written) -> DRAINING (first read issued) -> EMPTY (k = N-1 accepted downstream).
REQ-007 The writer SHALL target bank 0 after reset and toggle banks after each pair 511; the reader SHALL drain banks in the same order.
REQ-008 If i_valid_in is high and the write-target bank is not EMPTY or FILLING, the pair SHALL be dropped, the pair counter SHALL NOT advance, and o_overflow SHALL be set until reset.
REQ-009 A bank that becomes EMPTY SHALL accept writes in the same cycle it becomes EMPTY.
REQ-010 The reader SHALL emit k = 0..N-1 in increasing order, one sample per cycle while i_ready is high.
REQ-011 Reads SHALL use the 1-cycle synchronous RAM read; a 2-entry output skid buffer SHALL absorb i_ready deassertion.
REQ-012 No sample SHALL be lost or duplicated under any i_ready pattern.
REQ-013 o_data_*, o_index, o_sof and o_eof SHALL hold stable while o_valid_out = 1 and i_ready = 0.
REQ-014 Latency: with i_ready held high, o_valid_out for k = 0 SHALL rise exactly 3 cycles after the cycle in which pair 511 is accepted.
REQ-015 With i_ready held high, output SHALL be gap-free across bank boundaries when the next bank is already FULL.
REQ-016 Input duty above 50% sustained SHALL eventually cause overflow per REQ-008; the block SHALL NOT stall or corrupt the bank being drained.
REQ-017 Data SHALL pass bit-exact: no scaling, rounding or saturation.

Reset
REQ-018 On i_reset low, all of the following SHALL be forced asynchronously:
- o_valid_out, o_sof, o_eof, o_overflow = 0.
- o_data_real, o_data_imag, o_index = 0.
- Both banks EMPTY; pair counter, read counter, write bank select and read bank select = 0; skid buffer empty.
REQ-019 Reset asserted mid-frame SHALL discard all partial and full frames; after release, the first valid pair SHALL be treated as p = 0.
REQ-020 RAM contents SHALL NOT require reset.

Structure
REQ-021 Package fft_pkg SHALL hold:
- FFT_N_LOG2 = 10, FFT_N = 1024, DATA_W = 32.
- typedef bank_state_t {EMPTY, FILLING, FULL, DRAINING}.
- function bitrev(width, value).
REQ-022 The block SHALL instantiate the existing dual_port_ram sub-module: 2 banks x real/imag = 4 instances.
- Port A and port B write A and B samples during fill.
- Port A reads during drain.

Verification
REQ-023 Directed scenarios the bench SHALL cover:
- Single frame, A = {re 2p, im -2p}, B = {re 2p+1, im -(2p+1)}, 512 consecutive pairs, i_ready = 1 -> 1024 outputs, k = 0..1023; o_data_real = bitrev(k) mapped value; o_sof at k = 0, o_eof at k = 1023; first output 3 cycles after last pair.
- Three back-to-back frames at 50% input duty, i_ready = 1 -> 3072 outputs, no gaps after the first, o_overflow = 0.
- Random i_ready (30% low) over 2 frames -> outputs identical to reference model, data held stable while stalled.
- i_ready = 0 throughout, 3 frames pushed at full rate -> frames 1 and 2 stored, first pair of frame 3 dropped, o_overflow = 1; releasing i_ready yields frames 1 and 2 only.
- Reset asserted at pair 300 of frame 2 while frame 1 is draining -> outputs 0 within the reset; after release, a fresh frame is output correctly with o_overflow = 0.
- Pair 511 written in the same cycle the draining bank's k = 1023 is accepted -> no drop; next frame begins filling correctly.
